// File: rtl/fpu_pkg.sv
// Shared FP32 definitions for the adder result path.
// Field positions, adder latency, and the result-buffer entry width.
package fpu_pkg;

  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int MAN_W    = 23;
  localparam int EXP_LSB  = MAN_W;

  // Edges from adder operand regs to adder out: reg -> NORMMEM -> out
  localparam int FPADD_LATENCY = 3;

  typedef logic [31:0] fp32_t;

`ifdef FPADD_RESULT_FLAGS_EN
  // {zero, neg, data}
  localparam int RES_W = 34;
`else
  localparam int RES_W = 32;
`endif

  function automatic logic fp32_is_zero(fp32_t x);
    return x[EXP_MSB:0] == '0;
  endfunction

  function automatic logic [EXP_MSB-EXP_LSB:0] fp32_exp(fp32_t x);
    return x[EXP_MSB:EXP_LSB];
  endfunction

endpackage

// File: rtl/fpadd_sync_fifo.sv
// Synchronous FIFO with occupancy count and flop-based read port.
// Ports: clk, reset, push_i/wdata_i, pop_i, rdata_o (0 when empty), count_o.
module fpadd_sync_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          pop_i,
  output logic [W-1:0]  rdata_o,
  output logic [CW-1:0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          pop_ok;

  // Popping an empty FIFO is a no-op
  assign pop_ok = pop_i & (count_q != '0);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    // Pointers wrap naturally: DEPTH is a power of two
    if (push_i) wptr_d = wptr_q + 1'b1;
    if (pop_ok) rptr_d = rptr_q + 1'b1;
    unique case ({push_i, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q] <= wdata_i;
  end

  // Storage is not reset; mask the head so it reads 0 while empty
  assign rdata_o = (count_q != '0) ? mem_q[rptr_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/fpadd_result_buffer.sv
// Valid/ready wrapper around the free-running FP32 adder pipeline.
// Ports: in_* operand handshake, add_a/add_b/add_out adder link,
// res_* result handshake, level = buffered + in-flight results.
// FPADD_RESULT_FLAGS_EN adds res_zero/res_neg captured with each result.
module fpadd_result_buffer
  import fpu_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int ADD_LATENCY = FPADD_LATENCY,
  parameter int CW          = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_a,
  input  logic [31:0]   in_b,
  output logic [31:0]   add_a,
  output logic [31:0]   add_b,
  input  logic [31:0]   add_out,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [31:0]   res_data,
`ifdef FPADD_RESULT_FLAGS_EN
  output logic          res_zero,
  output logic          res_neg,
`endif
  output logic [CW-1:0] level
);

  logic                   fire;
  logic                   push;
  logic                   pop;
  logic [ADD_LATENCY-1:0] vpipe_q, vpipe_d;
  logic [CW-1:0]          count;
  logic [CW-1:0]          inflight;
  logic [RES_W-1:0]       wdata;
  logic [RES_W-1:0]       rdata;

  // Credit check uses registered state only, so a pop this cycle
  // cannot combinationally raise in_ready
  assign in_ready = level < CW'(DEPTH);
  assign fire     = in_valid & in_ready;

  // Idle operands are zeroed to keep the adder quiet
  assign add_a = fire ? in_a : '0;
  assign add_b = fire ? in_b : '0;

  always_comb begin
    vpipe_d    = '0;
    vpipe_d[0] = fire;
    for (int i = 1; i < ADD_LATENCY; i++) begin
      vpipe_d[i] = vpipe_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) vpipe_q <= '0;
    else       vpipe_q <= vpipe_d;
  end

  always_comb begin
    inflight = '0;
    for (int i = 0; i < ADD_LATENCY; i++) begin
      inflight = inflight + CW'(vpipe_q[i]);
    end
  end

  // Oldest vpipe stage lines up with the adder's output word
  assign push = vpipe_q[ADD_LATENCY-1];
  assign pop  = res_valid & res_ready;

`ifdef FPADD_RESULT_FLAGS_EN
  assign wdata = {fp32_is_zero(add_out), add_out[SIGN_BIT], add_out};
`else
  assign wdata = add_out;
`endif

  fpadd_sync_fifo #(
    .W     (RES_W),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .wdata_i (wdata),
    .pop_i   (pop),
    .rdata_o (rdata),
    .count_o (count)
  );

  assign res_valid = count != '0;
  assign res_data  = rdata[31:0];
  assign level     = count + inflight;

`ifdef FPADD_RESULT_FLAGS_EN
  assign res_neg  = rdata[32];
  assign res_zero = rdata[33];
`endif

endmodule

// File: tb/tb_fpadd_result_buffer.sv
// Self-checking bench for fpadd_result_buffer with a 3-stage adder model.
// Table-driven vectors plus a scoreboard queue checking every popped result.
module tb_fpadd_result_buffer;
  import fpu_pkg::*;

  localparam int DEPTH = 8;
  localparam int LAT   = 3;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_a, in_b;
  logic [31:0]   add_a, add_b, add_out;
  logic          res_valid, res_ready;
  logic [31:0]   res_data;
  logic [CW-1:0] level;
`ifdef FPADD_RESULT_FLAGS_EN
  logic          res_zero, res_neg;
`endif

  always #5 clk = ~clk;

  fpadd_result_buffer #(
    .DEPTH       (DEPTH),
    .ADD_LATENCY (LAT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_out   (add_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
`ifdef FPADD_RESULT_FLAGS_EN
    .res_zero  (res_zero),
    .res_neg   (res_neg),
`endif
    .level     (level)
  );

  typedef struct {
    fp32_t a;
    fp32_t b;
    fp32_t s;
  } vec_t;

  vec_t vec [8];

  int errors = 0;
  int checks = 0;

  // Adder stand-in: table lookup for known pairs, integer sum otherwise
  function automatic fp32_t model_add(fp32_t a, fp32_t b);
    for (int i = 0; i < 8; i++) begin
      if (vec[i].a == a && vec[i].b == b) return vec[i].s;
    end
    return a + b;
  endfunction

  fp32_t s1 = '0, s2 = '0, s3 = '0;
  always @(posedge clk) begin
    s1 <= model_add(add_a, add_b);
    s2 <= s1;
    s3 <= s2;
  end
  assign add_out = s3;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  // Scoreboard
  fp32_t q[$];
  bit    mon_en = 1'b0;

  always @(negedge clk) begin
    if (mon_en && !reset) begin
      chk("level_bound", level <= DEPTH, 1);
      if (in_valid && in_ready) q.push_back(model_add(in_a, in_b));
      if (res_valid && res_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_empty: got 'h%0h, expected no result", res_data);
        end else begin
          fp32_t e;
          e = q.pop_front();
          chk("sb_data", res_data, e);
`ifdef FPADD_RESULT_FLAGS_EN
          chk("sb_neg", res_neg, e[31]);
          chk("sb_zero", res_zero, e[30:0] == 0);
`endif
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(int i);
    in_valid = 1'b1;
    in_a     = vec[i].a;
    in_b     = vec[i].b;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
  endtask

  // Pop until empty (bounded), then expect nothing outstanding
  task automatic drain(string name);
    int t;
    res_ready = 1'b1;
    t = 0;
    while (res_valid && t < 30) begin
      cyc();
      t++;
    end
    @(negedge clk);
    chk({name, "_empty"}, res_valid, 0);
    chk({name, "_level"}, level, 0);
    chk({name, "_sb"}, q.size(), 0);
  endtask

  initial begin
    int vcnt, vfirst, fires, idx, t;
    bit f;

    vec[0] = '{32'h3F800000, 32'h40000000, 32'h40400000};
    vec[1] = '{32'h40A00000, 32'hC0A00000, 32'h00000000};
    vec[2] = '{32'hC0000000, 32'h3F800000, 32'hBF800000};
    vec[3] = '{32'h3F800000, 32'h3F800000, 32'h40000000};
    vec[4] = '{32'h40400000, 32'h3F800000, 32'h40800000};
    vec[5] = '{32'h41200000, 32'h40A00000, 32'h41700000};
    vec[6] = '{32'h00000000, 32'h00000000, 32'h00000000};
    vec[7] = '{32'h3F000000, 32'h3F000000, 32'h3F800000};

    reset     = 1'b1;
    res_ready = 1'b0;
    idle();
    repeat (2) cyc();
    reset  = 1'b0;
    mon_en = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_valid", res_valid, 0);
    chk("rst_data", res_data, 0);
    chk("rst_level", level, 0);
    chk("rst_ready", in_ready, 1);

    // Single op: valid for exactly one cycle, 4 cycles after fire
    cyc();
    res_ready = 1'b1;
    drive(0);
    #1;
    chk("add_a_fire", add_a, vec[0].a);
    chk("add_b_fire", add_b, vec[0].b);
    cyc();
    idle();
    #1;
    chk("add_a_idle", add_a, 0);
    vcnt   = 0;
    vfirst = -1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 1) chk("single_level", level, 1);
      if (res_valid) begin
        if (vfirst < 0) begin
          vfirst = i;
          chk("single_data", res_data, 32'h40400000);
        end
        vcnt++;
      end
    end
    chk("single_vcnt", vcnt, 1);
    chk("single_lat", vfirst, 4);

    // Back-to-back: table applied on consecutive cycles
    cyc();
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          drive(i);
          cyc();
        end
        idle();
      end
      begin
        int got, prev, tt;
        got  = 0;
        prev = -1;
        tt   = 0;
        while (got < 8 && tt < 40) begin
          @(negedge clk);
          tt++;
          if (res_valid) begin
            chk("b2b_data", res_data, vec[got].s);
            if (got > 0) chk("b2b_nobubble", tt, prev + 1);
            prev = tt;
            got++;
          end
        end
        chk("b2b_count", got, 8);
      end
    join

    // Backpressure: exactly DEPTH fires, then drain in order
    cyc();
    res_ready = 1'b0;
    fires     = 0;
    idx       = 0;
    drive(0);
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      f = in_ready;
      if (f) fires++;
      cyc();
      if (f) begin
        idx++;
        drive(idx % 8);
      end
    end
    idle();
    @(negedge clk);
    chk("bp_fires", fires, DEPTH);
    chk("bp_level", level, DEPTH);
    chk("bp_ready", in_ready, 0);
    chk("bp_head", res_data, vec[0].s);
    cyc();
    res_ready = 1'b1;
    cyc();
    @(negedge clk);
    chk("bp_recover", in_ready, 1);
    chk("bp_level7", level, DEPTH - 1);
    chk("bp_head2", res_data, vec[1].s);
    cyc();
    drain("bp");

    // Push and pop together at count=DEPTH-1, across pointer wrap
    cyc();
    res_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      drive(i);
      cyc();
    end
    idle();
    repeat (4) cyc();
    @(negedge clk);
    chk("sim_fill", level, DEPTH - 1);
    cyc();
    drive(7);
    cyc();
    idle();
    cyc();
    cyc();
    res_ready = 1'b1;
    @(negedge clk);
    chk("sim_pre_level", level, DEPTH);
    chk("sim_pre_ready", in_ready, 0);
    cyc();
    res_ready = 1'b0;
    @(negedge clk);
    chk("sim_level", level, DEPTH - 1);
    chk("sim_valid", res_valid, 1);
    chk("sim_head", res_data, vec[1].s);
    cyc();
    drain("sim");

    // Reset with 2 buffered and 3 in flight
    cyc();
    res_ready = 1'b0;
    drive(2);
    cyc();
    drive(3);
    cyc();
    idle();
    repeat (4) cyc();
    for (int i = 4; i < 7; i++) begin
      drive(i);
      cyc();
    end
    idle();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    q.delete();
    res_ready = 1'b1;
    @(negedge clk);
    chk("mrst_valid", res_valid, 0);
    chk("mrst_level", level, 0);
    chk("mrst_ready", in_ready, 1);
    vcnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (res_valid) vcnt++;
    end
    chk("mrst_stale", vcnt, 0);

`ifdef FPADD_RESULT_FLAGS_EN
    // Flags travel with the data
    cyc();
    res_ready = 1'b0;
    drive(2);
    cyc();
    drive(1);
    cyc();
    idle();
    t = 0;
    @(negedge clk);
    while (!res_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("flag_data", res_data, 32'hBF800000);
    chk("flag_neg", res_neg, 1);
    chk("flag_zero", res_zero, 0);
    cyc();
    res_ready = 1'b1;
    cyc();
    res_ready = 1'b0;
    @(negedge clk);
    chk("flag_data2", res_data, 32'h00000000);
    chk("flag_zero2", res_zero, 1);
    chk("flag_neg2", res_neg, 0);
    cyc();
    drain("flag");
`else
    t = 0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
